// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: accumulator ALU behind a valid/ready command channel.
// Each accepted command executes once and is answered on a held response channel.
module alu_cmd_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_sticky,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    // ALU: combinational result and signed overflow from acc and captured operand
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            3'b000: begin
                alu_res = acc_q + b_q;
                alu_ovf = (acc_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res = acc_q - b_q;
                alu_ovf = (acc_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            3'b010: alu_res = acc_q & b_q;
            3'b011: alu_res = acc_q | b_q;
            3'b100: alu_res = acc_q ^ b_q;
            3'b101: alu_res = {acc_q[WIDTH-2:0], 1'b0};
            3'b110: alu_res = {1'b0, acc_q[WIDTH-1:1]};
            3'b111: alu_res = b_q;
        endcase
    end

    // Next-state and datapath update for the accept / execute / respond cycle
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        // A clear is overridden below when the same cycle reports overflow
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    b_d     = cmd_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                acc_d   = alu_res;
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                ovf_d   = alu_ovf;
                valid_d = 1'b1;
                if (alu_ovf) begin
                    sticky_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = valid_q;
    assign rsp_result   = res_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;
    assign acc          = acc_q;
    assign ovf_sticky   = sticky_q;
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: directed and random commands against a transaction-level
// accumulator model, compared on every falling edge.
module tb_alu_cmd_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_b = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_overflow;
    logic [7:0] acc;
    logic       ovf_sticky;
    logic       sticky_clr = 1'b0;
    logic [7:0] op_count;

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 0;
    bit rr_rand = 0;
    bit clr_rand = 0;

    alu_cmd_engine #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .acc(acc),
        .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit       m_busy = 0;
    bit       m_valid = 0;
    bit       m_zero = 0;
    bit       m_ovf = 0;
    bit       m_sticky = 0;
    bit       m_set;
    logic [2:0] m_op = '0;
    logic [7:0] m_b = '0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_res = '0;
    logic [7:0] m_cnt = '0;
    int       ma, mb, mr, ms;

    function automatic int sx(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_zero = 0; m_ovf = 0;
            m_sticky = 0; m_acc = '0; m_res = '0; m_cnt = '0;
        end else begin
            m_set = 0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1;
                    m_op = cmd_op;
                    m_b = cmd_b;
                end
            end else if (!m_valid) begin
                ma = int'(m_acc);
                mb = int'(m_b);
                ms = 0;
                case (m_op)
                    3'd0: begin mr = (ma + mb) % 256; ms = sx(m_acc) + sx(m_b); end
                    3'd1: begin mr = (ma - mb + 256) % 256; ms = sx(m_acc) - sx(m_b); end
                    3'd2: mr = ma & mb;
                    3'd3: mr = ma | mb;
                    3'd4: mr = ma ^ mb;
                    3'd5: mr = (ma * 2) % 256;
                    3'd6: mr = ma / 2;
                    default: mr = mb;
                endcase
                m_ovf = (ms > 127) || (ms < -128);
                m_acc = mr[7:0];
                m_res = mr[7:0];
                m_zero = (mr == 0);
                m_valid = 1;
                m_set = m_ovf;
            end else if (rsp_ready) begin
                m_valid = 0;
                m_busy = 0;
                m_cnt = m_cnt + 8'd1;
            end
            m_sticky = m_set | (m_sticky & !sticky_clr);
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_valid);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_overflow", rsp_overflow, m_ovf);
            chk("acc", acc, m_acc);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            chk("op_count", op_count, m_cnt);
        end
    end

    // Random back-pressure and sticky clears during the random phase
    always @(negedge clk) begin
        if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
        if (clr_rand) sticky_clr = ($urandom_range(0, 7) == 0);
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input logic [7:0] b,
                        input bit lit, input logic [7:0] eres,
                        input bit eovf, input bit wait_done,
                        input bit clr_exec);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_b = b;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_b = 8'($urandom);
        if (clr_exec) sticky_clr = 1'b1;
        if (lit) chk("lat_exec_valid", rsp_valid, 0);
        @(negedge clk);
        if (clr_exec) sticky_clr = 1'b0;
        if (lit) begin
            chk("lat_rsp_valid", rsp_valid, 1);
            chk("lit_result", rsp_result, eres);
            chk("lit_overflow", rsp_overflow, eovf);
            chk("lit_zero", rsp_zero, (eres == 8'h00));
        end
        if (wait_done) begin
            t = 0;
            while (!cmd_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!cmd_ready) chk("done_timeout", 0, 1);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_cleared", ovf_sticky, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_acc", acc, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_result", rsp_result, 0);
        rst_n = 1'b1;
        check_en = 1;
        rsp_ready = 1'b1;

        send(3'b111, 8'h25, 1, 8'h25, 0, 1, 0);
        send(3'b000, 8'h1A, 1, 8'h3F, 0, 1, 0);
        chk("count_two", op_count, 2);

        send(3'b111, 8'h7F, 1, 8'h7F, 0, 1, 0);
        send(3'b000, 8'h01, 1, 8'h80, 1, 1, 0);
        chk("sticky_add_ovf", ovf_sticky, 1);
        send(3'b111, 8'h80, 1, 8'h80, 0, 1, 0);
        send(3'b001, 8'h01, 1, 8'h7F, 1, 1, 0);
        send(3'b111, 8'h00, 1, 8'h00, 0, 1, 0);
        chk("sticky_held", ovf_sticky, 1);

        send(3'b111, 8'hAA, 1, 8'hAA, 0, 1, 0);
        send(3'b101, 8'h5C, 1, 8'h54, 0, 1, 0);
        send(3'b110, 8'hFF, 1, 8'h2A, 0, 1, 0);
        send(3'b010, 8'hCC, 1, 8'h08, 0, 1, 0);
        send(3'b011, 8'hF0, 1, 8'hF8, 0, 1, 0);
        send(3'b100, 8'hFF, 1, 8'h07, 0, 1, 0);

        pulse_clr();
        send(3'b111, 8'h7F, 1, 8'h7F, 0, 1, 0);
        send(3'b000, 8'h01, 1, 8'h80, 1, 1, 1);
        chk("sticky_set_wins", ovf_sticky, 1);
        pulse_clr();

        rsp_ready = 1'b0;
        send(3'b111, 8'h55, 1, 8'h55, 0, 0, 0);
        cmd_valid = 1'b1;
        cmd_op = 3'b111;
        cmd_b = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 8'h55);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_count", op_count, 15);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", cmd_ready, 1);
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_count", op_count, 16);
        chk("bp_acc_kept", acc, 8'h55);

        rsp_ready = 1'b0;
        send(3'b000, 8'h01, 1, 8'h56, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_result", rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("after_rst_count", op_count, 0);

        rr_rand = 1;
        clr_rand = 1;
        repeat (256) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(3'($urandom), 8'($urandom), 0, 8'h00, 0, 1, 0);
        end
        rr_rand = 0;
        clr_rand = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        sticky_clr = 1'b0;
        chk("count_wrap", op_count, 0);

        repeat (2) @(negedge clk);
        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
